fetch_unit: RTL

Parametrised instruction-fetch stage for the ARM-subset pipeline, replacing the fixed-array fetch with a PC generator, an external instruction-memory request/acknowledge interface and a prefetch queue. Sits between the instruction memory and the IF/ID boundary. It accepts branch redirects from EXE and presents fetched instructions to decode under a valid/ready handshake, so stalls (freeze) and variable memory latency are decoupled.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 51 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Pointer width for a power-of-two queue depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch queue: registered storage, combinational head, flush clears pointers.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generator, single-outstanding memory request, prefetch queue to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         QDEPTH   = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc4
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = ptr_w(QDEPTH) + 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   target;
  logic                q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0]    q_count;
  logic [ENTRY_W-1:0]  q_rdata;

  assign target = branch_addr & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      hold_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // In DROP the old address stays on the bus while pc already holds the redirect target.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    q_push    = 1'b0;
    unique case (state_q)
      RUN: begin
        imem_req = (q_count < CNT_W'(QDEPTH));
        if (branch_taken) begin
          pc_d = target;
          if (imem_req && !imem_ack) begin
            state_d = DROP;
            hold_d  = pc_q;
          end
        end else if (imem_req && imem_ack && !q_full) begin
          q_push = 1'b1;
          pc_d   = pc_q + ADDR_W'(WORD_BYTES);
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = hold_q;
        if (branch_taken) pc_d = target;
        if (imem_ack) state_d = RUN;
      end
    endcase
    if (rst) begin
      imem_req = 1'b0;
      q_push   = 1'b0;
    end
  end

  assign q_pop = !q_empty && out_ready;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (branch_taken),
    .wdata ({imem_addr, imem_rdata}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign out_valid = !q_empty;
  assign out_instr = out_valid ? q_rdata[DATA_W-1:0] : '0;
  assign out_pc    = out_valid ? q_rdata[ENTRY_W-1:DATA_W] : '0;
  assign out_pc4   = out_valid ? q_rdata[ENTRY_W-1:DATA_W] + ADDR_W'(WORD_BYTES) : '0;

endmodule
